ram_burst_master: RTL

- Bus initiator for the single-port synchronous RAM (address / bidirectional data / write / en / clk).
- Accepts burst commands (start address, length, direction) from a client over a valid/ready handshake.
- Write bursts take data from a valid/ready stream; read bursts return data on a valid-only stream.
- Owns all RAM control pins and the master side of the tristate data bus, including bus turnaround.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_burst_master.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_pkg                                                              |
// | Shared state encoding and bus constants for the RAM burst master.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_pkg;

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_WRITE    = 3'd1;
  localparam logic [2:0] c_ST_WR_FLUSH = 3'd2;
  localparam logic [2:0] c_ST_RD_ISSUE = 3'd3;
  localparam logic [2:0] c_ST_RD_DRAIN = 3'd4;
  localparam logic [2:0] c_ST_TURN     = 3'd5;

  localparam logic c_CMD_READ  = 1'b0;
  localparam logic c_CMD_WRITE = 1'b1;

  // One bit of a released (undriven) data bus.
  localparam logic c_BUS_Z = 1'bz;

endpackage
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_burst_master                                                     |
// | Burst initiator for a single-port synchronous RAM with shared bus.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int A_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [A_SIZE-1:0] cmd_addr,
  input  logic [A_SIZE-1:0] cmd_len,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              busy,
  output logic [A_SIZE-1:0] ram_address,
  inout  wire  [WIDTH-1:0]  ram_data,
  output logic              ram_write,
  output logic              ram_en
);

  logic [2:0]        r_state;
  logic [A_SIZE-1:0] r_addr;
  logic [A_SIZE-1:0] r_remain;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_rd_pend;

  assign cmd_ready = (r_state == c_ST_IDLE);
  assign busy      = (r_state != c_ST_IDLE);
  assign wr_ready  = (r_state == c_ST_WRITE);

  // Only a write cycle may put the master on the bus.
  assign ram_data = (ram_en && ram_write) ? r_wdata : {WIDTH{c_BUS_Z}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_wdata     <= '0;
      r_rd_pend   <= 1'b0;
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      // An issue cycle's word is on the bus one cycle later and presented the cycle after.
      r_rd_pend <= (r_state == c_ST_RD_ISSUE);
      rd_valid  <= r_rd_pend;
      if (r_rd_pend) begin
        rd_data <= ram_data;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_remain    <= cmd_len;
            ram_address <= cmd_addr;
            case (cmd_write)
              c_CMD_WRITE: begin
                r_addr  <= cmd_addr;
                r_state <= c_ST_WRITE;
              end
              c_CMD_READ: begin
                ram_en    <= 1'b1;
                ram_write <= 1'b0;
                r_state   <= c_ST_RD_ISSUE;
              end
            endcase
          end
        end

        c_ST_WRITE: begin
          if (wr_valid) begin
            ram_en      <= 1'b1;
            ram_write   <= 1'b1;
            ram_address <= r_addr;
            r_wdata     <= wr_data;
            r_addr      <= r_addr + 1'b1;
            r_remain    <= r_remain - 1'b1;
            if (r_remain == '0) begin
              r_state <= c_ST_WR_FLUSH;
            end
          end else begin
            ram_en    <= 1'b0;
            ram_write <= 1'b0;
          end
        end

        c_ST_WR_FLUSH: begin
          ram_en    <= 1'b0;
          ram_write <= 1'b0;
          done      <= 1'b1;
          r_state   <= c_ST_IDLE;
        end

        c_ST_RD_ISSUE: begin
          if (r_remain == '0) begin
            r_state <= c_ST_RD_DRAIN;
          end else begin
            ram_address <= ram_address + 1'b1;
            r_remain    <= r_remain - 1'b1;
          end
        end

        // Enable stays up one more cycle so the RAM keeps the last word on the bus.
        c_ST_RD_DRAIN: begin
          ram_en  <= 1'b0;
          done    <= 1'b1;
          r_state <= c_ST_TURN;
        end

        c_ST_TURN: begin
          r_state <= c_ST_IDLE;
        end

        default: begin
          ram_en    <= 1'b0;
          ram_write <= 1'b0;
          r_state   <= c_ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
